uc_ctrl: RTL and testbench

- Control unit for the `microc` single-cycle datapath: the other end of its control interface.
- Decodes `Opcode` and `z` each cycle and drives `s_inc`, `s_inm`, `we3`, `wez` and `Op`, which benches currently drive by hand.
- Adds run/pause/single-step/halt sequencing, a sticky illegal-opcode flag and a retired-instruction counter for debug.
- Adds `pc_en`, consumed by the PC register enable in the datapath revision that accompanies this block.

---
 rtl/uc_ctrl_pkg.sv | 28 ++
 rtl/uc_ctrl_decoder.sv | 41 ++++
 rtl/uc_ctrl.sv | 115 +++++++++++
 tb/tb_uc_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_ctrl_pkg.sv
// Shared opcode classes, FSM state encoding and the raw control bundle of
// the microc control unit.
package uc_ctrl_pkg;

  localparam logic [3:0] OPC_LI   = 4'b1000;
  localparam logic [3:0] OPC_J    = 4'b1001;
  localparam logic [3:0] OPC_JZ   = 4'b1010;
  localparam logic [3:0] OPC_JNZ  = 4'b1011;
  localparam logic [5:0] OPC_HALT = 6'b111111;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSE  = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } uc_state_e;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic       pc_en;
    logic [2:0] op;
  } uc_ctl_t;

endpackage

// File: rtl/uc_ctrl_decoder.sv
// Combinational opcode/zero-flag decode into raw (ungated) datapath controls.
module uc_decoder
  import uc_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OPC = OPC_HALT
) (
  input  logic [5:0] opcode_i,
  input  logic       z_i,
  output uc_ctl_t    ctl_o,
  output logic       is_halt_o,
  output logic       is_illegal_o
);

  always_comb begin
    ctl_o        = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0,
                     pc_en: 1'b1, op: 3'b000};
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    // Halt is matched first so it wins over any class it overlaps.
    if (opcode_i == HALT_OPC) begin
      ctl_o.pc_en = 1'b0;
      is_halt_o   = 1'b1;
    end else if (!opcode_i[5]) begin
      ctl_o.op  = opcode_i[4:2];
      ctl_o.we3 = 1'b1;
      ctl_o.wez = 1'b1;
    end else begin
      case (opcode_i[5:2])
        OPC_LI: begin
          ctl_o.s_inm = 1'b1;
          ctl_o.we3   = 1'b1;
        end
        OPC_J:   ctl_o.s_inc = 1'b0;
        OPC_JZ:  ctl_o.s_inc = ~z_i;
        OPC_JNZ: ctl_o.s_inc = z_i;
        default: is_illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uc_ctrl.sv
// microc control unit: decode, run/pause/step/halt sequencing, sticky
// illegal-opcode flag and saturating retired-instruction counter.
module uc_ctrl
  import uc_ctrl_pkg::*;
#(
  parameter int         ICW      = 16,
  parameter logic [5:0] HALT_OPC = OPC_HALT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [5:0]     Opcode,
  input  logic           z,
  input  logic           run,
  input  logic           step,
  output logic           s_inc,
  output logic           s_inm,
  output logic           we3,
  output logic           wez,
  output logic [2:0]     Op,
  output logic           pc_en,
  output logic           halted,
  output logic           illegal,
  output logic [ICW-1:0] icount,
  output uc_state_e      dbg_state_o
);

  uc_state_e      state_q, state_d;
  logic           step_q;
  logic           illegal_q, illegal_d;
  logic [ICW-1:0] icount_q, icount_d;
  uc_ctl_t        ctl;
  logic           is_halt, is_illegal;
  logic           exec, step_rise;

  uc_decoder #(.HALT_OPC(HALT_OPC)) u_dec (
    .opcode_i     (Opcode),
    .z_i          (z),
    .ctl_o        (ctl),
    .is_halt_o    (is_halt),
    .is_illegal_o (is_illegal)
  );

  assign exec      = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign step_rise = step & ~step_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = run ? ST_RUN : ST_PAUSE;
      ST_RUN: begin
        if (is_halt)   state_d = ST_HALTED;
        else if (!run) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (run)            state_d = ST_RUN;
        else if (step_rise) state_d = ST_STEP;
      end
      ST_STEP: begin
        if (is_halt)  state_d = ST_HALTED;
        else if (run) state_d = ST_RUN;
        else          state_d = ST_PAUSE;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    icount_d  = icount_q;
    illegal_d = illegal_q;
    if (exec && !is_halt && (icount_q != '1)) icount_d = icount_q + ICW'(1);
    if (exec && is_illegal) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      step_q    <= 1'b0;
      illegal_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step;
      illegal_q <= illegal_d;
      icount_q  <= icount_d;
    end
  end

  // Reset is used combinationally so outputs settle in the same delta as the
  // asynchronous clear, with no partial write leaking through.
  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    Op    = 3'b000;
    pc_en = 1'b0;
    if (reset) begin
      s_inc = ctl.s_inc;
      s_inm = ctl.s_inm;
      Op    = ctl.op;
      if (exec) begin
        we3   = ctl.we3;
        wez   = ctl.wez;
        pc_en = ctl.pc_en;
      end
    end
  end

  assign halted      = (state_q == ST_HALTED);
  assign illegal     = illegal_q;
  assign icount      = icount_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uc_ctrl.sv
// Bench for uc_ctrl: a small microc datapath model runs a program, then
// directed decode vectors and hand-written run/pause/step/reset sequences.
module tb_uc_ctrl;
  import uc_ctrl_pkg::*;

  localparam int ICW = 16;

  logic           clk;
  logic           reset;
  logic [5:0]     opcode;
  logic           z_in;
  logic           run;
  logic           step;
  logic           s_inc, s_inm, we3, wez, pc_en, halted, illegal;
  logic [2:0]     op;
  logic [ICW-1:0] icount;
  uc_state_e      dbg_state;

  int n_run  = 0;
  int n_fail = 0;

  uc_ctrl #(.ICW(ICW), .HALT_OPC(OPC_HALT)) dut (
    .clk         (clk),
    .reset       (reset),
    .Opcode      (opcode),
    .z           (z_in),
    .run         (run),
    .step        (step),
    .s_inc       (s_inc),
    .s_inm       (s_inm),
    .we3         (we3),
    .wez         (wez),
    .Op          (op),
    .pc_en       (pc_en),
    .halted      (halted),
    .illegal     (illegal),
    .icount      (icount),
    .dbg_state_o (dbg_state)
  );

  // Clock: posedges at 10, 20, ...; negedges at 5, 15, ...
  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Datapath model: PC, instruction memory, register file, ALU, zero flag.
  logic        use_imem;
  logic [5:0]  opc_drv;
  logic        z_drv;
  logic [15:0] imem [16];
  logic [3:0]  pc_m;
  logic [7:0]  rf [16];
  logic        z_m;
  logic [15:0] instr;
  logic [7:0]  alu_a, alu_b, alu_y;

  assign instr  = imem[pc_m];
  assign opcode = use_imem ? instr[15:10] : opc_drv;
  assign z_in   = use_imem ? z_m : z_drv;
  assign alu_a  = rf[instr[11:8]];
  assign alu_b  = rf[instr[7:4]];

  always_comb begin
    alu_y = 8'h00;
    case (op)
      3'b000: alu_y = alu_a;
      3'b001: alu_y = ~alu_a;
      3'b010: alu_y = alu_a + alu_b;
      3'b011: alu_y = alu_a - alu_b;
      3'b100: alu_y = alu_a & alu_b;
      3'b101: alu_y = alu_a | alu_b;
      3'b110: alu_y = -alu_a;
      default: alu_y = -alu_b;
    endcase
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_m <= '0;
      z_m  <= 1'b0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      if (pc_en) pc_m <= s_inc ? pc_m + 4'd1 : instr[3:0];
      if (we3) rf[instr[3:0]] <= s_inm ? instr[11:4] : alu_y;
      if (wez) z_m <= (alu_y == 8'h00);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0] opc;
    logic       z;
    logic [7:0] exp;   // {s_inc, s_inm, we3, wez, pc_en, op[2:0]}
  } vec_t;

  vec_t vecs[12];
  int   jumps;
  bit   saw_halt;

  initial begin
    vecs[0]  = '{6'b000000, 1'b0, 8'b1011_1000};
    vecs[1]  = '{6'b001011, 1'b0, 8'b1011_1010};
    vecs[2]  = '{6'b001101, 1'b1, 8'b1011_1011};
    vecs[3]  = '{6'b011110, 1'b0, 8'b1011_1111};
    vecs[4]  = '{6'b100001, 1'b0, 8'b1110_1000};
    vecs[5]  = '{6'b100111, 1'b1, 8'b0000_1000};
    vecs[6]  = '{6'b101000, 1'b0, 8'b1000_1000};
    vecs[7]  = '{6'b101010, 1'b1, 8'b0000_1000};
    vecs[8]  = '{6'b101101, 1'b0, 8'b0000_1000};
    vecs[9]  = '{6'b101111, 1'b1, 8'b1000_1000};
    vecs[10] = '{6'b110000, 1'b0, 8'b1000_1000};
    vecs[11] = '{6'b111110, 1'b0, 8'b1000_1000};

    for (int i = 0; i < 16; i++) imem[i] = 16'hFC00;
    imem[0] = 16'h8002;  // li 0,R2
    imem[1] = 16'h8021;  // li 2,R1
    imem[2] = 16'h8043;  // li 4,R3
    imem[3] = 16'h8014;  // li 1,R4
    imem[4] = 16'h2232;  // loop: add R2,R3,R2
    imem[5] = 16'h3141;  // sub R1,R4,R1
    imem[6] = 16'hB004;  // jnz loop
    imem[7] = 16'hFC00;  // halt

    // Reset values, with an ALU opcode present to show everything is forced.
    reset = 1'b0; run = 1'b1; step = 1'b0;
    use_imem = 1'b0; opc_drv = 6'b001000; z_drv = 1'b0;
    #12;
    check("rst_outs", {s_inc, s_inm, we3, wez, pc_en, op}, 8'b1000_0000);
    check("rst_flags", {halted, illegal}, 2'b00);
    check("rst_icount", icount, 0);
    check("rst_state", dbg_state, ST_BOOT);

    // Program run.
    use_imem = 1'b1;
    #3 reset = 1'b1;   // t=15
    #1;
    check("boot_state", dbg_state, ST_BOOT);
    check("boot_pc_en", pc_en, 0);
    @(negedge clk); #1;
    check("boot_one_cycle", dbg_state, ST_RUN);
    jumps = 0; saw_halt = 1'b0;
    for (int c = 0; c < 40 && !halted; c++) begin
      if (pc_en && !s_inc) jumps++;
      if (opcode == OPC_HALT && !saw_halt) begin
        saw_halt = 1'b1;
        check("halt_pc_en", pc_en, 0);
      end
      @(negedge clk); #1;
    end
    check("prog_halted", halted, 1);
    check("prog_r2", rf[2], 8);
    check("prog_icount", icount, 10);
    check("prog_jumps", jumps, 1);
    check("prog_pc", pc_m, 7);
    check("prog_illegal", illegal, 0);

    // Async reset while HALTED.
    #2 reset = 1'b0;
    #1;
    check("halt_rst_flags", {halted, pc_en, we3, wez}, 4'b0000);
    check("halt_rst_icount", icount, 0);
    check("halt_rst_state", dbg_state, ST_BOOT);

    // Decode table in RUN with driven opcodes.
    use_imem = 1'b0; opc_drv = 6'b000000; z_drv = 1'b0; run = 1'b1;
    @(negedge clk); reset = 1'b1;
    #1 check("reboot_state", dbg_state, ST_BOOT);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      opc_drv = vecs[i].opc;
      z_drv   = vecs[i].z;
      #1;
      check($sformatf("dec_%0d", i), {s_inc, s_inm, we3, wez, pc_en, op}, vecs[i].exp);
    end
    @(negedge clk); #1;
    check("tbl_icount", icount, 12);
    check("tbl_illegal", illegal, 1);

    // Run low for 5 cycles: first still executes, then 5 idle cycles.
    opc_drv = 6'b001000; run = 1'b0;
    #1 check("pause_last_exec", {we3, pc_en}, 2'b11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) run = 1'b1;
      #1;
      check($sformatf("pause_en_%0d", i), {pc_en, we3, wez}, 3'b000);
      check($sformatf("pause_icount_%0d", i), icount, 13);
    end
    @(negedge clk); #1;
    check("resume_state", dbg_state, ST_RUN);
    check("resume_pc_en", pc_en, 1);
    check("resume_icount", icount, 13);

    // Step held high for 4 cycles, then a second short pulse.
    run = 1'b0;
    @(negedge clk); step = 1'b1; #1;
    check("step_pause", dbg_state, ST_PAUSE);
    check("step_pre_icount", icount, 14);
    @(negedge clk); #1;
    check("step_state", dbg_state, ST_STEP);
    check("step_pc_en", pc_en, 1);
    @(negedge clk); #1;
    check("step_back", dbg_state, ST_PAUSE);
    check("step_icount", icount, 15);
    @(negedge clk); #1;
    check("step_hold_pc_en", pc_en, 0);
    @(negedge clk); step = 1'b0; #1;
    check("step_hold_icount", icount, 15);
    check("step_hold_state", dbg_state, ST_PAUSE);
    @(negedge clk); step = 1'b1; #1;
    @(negedge clk); step = 1'b0; #1;
    check("step2_state", dbg_state, ST_STEP);
    @(negedge clk); #1;
    check("step2_icount", icount, 16);
    check("step2_back", dbg_state, ST_PAUSE);

    // Run and step rise together: run wins, no STEP cycle.
    run = 1'b1; step = 1'b1;
    @(negedge clk); #1;
    check("runstep_state", dbg_state, ST_RUN);
    check("runstep_icount", icount, 16);
    @(negedge clk); step = 1'b0; #1;
    check("runstep_icount2", icount, 17);

    // Async reset mid-RUN with an ALU write in flight.
    check("sticky_illegal", illegal, 1);
    check("midrun_we3", we3, 1);
    reset = 1'b0;
    #1;
    check("midrun_rst_outs", {s_inc, s_inm, we3, wez, pc_en, op}, 8'b1000_0000);
    check("midrun_rst_flags", {halted, illegal}, 2'b00);
    check("midrun_rst_icount", icount, 0);
    check("midrun_rst_state", dbg_state, ST_BOOT);
    @(negedge clk); reset = 1'b1; #1;
    check("restart_boot", dbg_state, ST_BOOT);
    check("restart_boot_pc_en", pc_en, 0);
    @(negedge clk); #1;
    check("restart_run", dbg_state, ST_RUN);
    check("restart_icount", icount, 0);
    @(negedge clk); #1;
    check("restart_icount1", icount, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
